// File: rtl/dm_bridge.sv
// dm_bridge: memory-side responder for the CPU data port.
//   Decodes m_data_addr and returns read data combinationally.
//   Stores are committed at posedge into a word-addressed data RAM (byte
//   enables honoured) or into a memory-mapped countdown timer that raises irq.
//   Optional feature: define DM_BRIDGE_TRACE_EN to print every committed write.
// Ports:
//   clk           - single clock
//   reset         - asynchronous, active-high; clears all state including RAM
//   m_data_addr   - byte address (bits [1:0] ignored for word indexing)
//   m_data_wdata  - store data, already lane-aligned
//   m_data_byteen - per-lane write enables, 4'b0000 = no write
//   m_inst_addr   - PC of the storing instruction, used only for tracing
//   m_data_rdata  - combinational read data
//   irq           - registered timer interrupt (flag & IM)
module dm_bridge #(
  parameter int          DM_WORDS   = 3072,
  parameter logic [31:0] TIMER_BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] m_data_rdata,
  output logic        irq
);

  localparam int          AW        = $clog2(DM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(4 * DM_WORDS);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  logic [31:0]   ram [DM_WORDS];
  logic [AW-1:0] word_idx;
  logic [31:0]   ram_word;
  logic [31:0]   ram_merged;
  logic          ram_sel, ctrl_sel, preset_sel, count_sel;
  logic          ram_we, ctrl_we, preset_we;

  logic [3:0]    ctrl, ctrl_d;
  logic [31:0]   preset, preset_d;
  logic [31:0]   count, count_d;
  logic          flag, flag_d;
  logic          irq_d;
  logic          en, auto_mode;
  state_t        state, state_d;

  // Address decode
  assign word_idx   = m_data_addr[AW+1:2];
  assign ram_sel    = (m_data_addr < RAM_BYTES);
  assign ctrl_sel   = (m_data_addr[31:2] == TIMER_BASE[31:2]);
  assign preset_sel = (m_data_addr[31:2] == TIMER_BASE[31:2] + 30'd1);
  assign count_sel  = (m_data_addr[31:2] == TIMER_BASE[31:2] + 30'd2);

  // Timer registers only accept full-word stores; COUNT is read-only.
  assign ram_we    = ram_sel & (|m_data_byteen);
  assign ctrl_we   = ctrl_sel & (&m_data_byteen);
  assign preset_we = preset_sel & (&m_data_byteen);

  assign ram_word = ram[word_idx];

  always_comb begin
    ram_merged = ram_word;
    for (int i = 0; i < 4; i++) begin
      if (m_data_byteen[i]) ram_merged[8*i +: 8] = m_data_wdata[8*i +: 8];
    end
  end

  always_comb begin
    m_data_rdata = '0;
    if (ram_sel)         m_data_rdata = ram_word;
    else if (ctrl_sel)   m_data_rdata = {28'b0, ctrl};
    else if (preset_sel) m_data_rdata = preset;
    else if (count_sel)  m_data_rdata = count;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) ram[i] <= '0;
    end else if (ram_we) begin
      ram[word_idx] <= ram_merged;
    end
  end

  // Timer FSM: state register
  assign en        = ctrl[0];
  assign auto_mode = (ctrl[2:1] == 2'b01);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Timer FSM: next state
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (en) state_d = LOAD;
      LOAD:    state_d = CNT;
      CNT: begin
        if (!en)                state_d = IDLE;
        else if (count <= 32'd1) state_d = INT;
      end
      INT:     state_d = auto_mode ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Timer FSM: register updates. A CPU CTRL write is applied last so it
  // overrides the EN clear and flag set done by INT in the same cycle.
  always_comb begin
    ctrl_d   = ctrl;
    preset_d = preset;
    count_d  = count;
    flag_d   = auto_mode ? 1'b0 : flag;
    case (state)
      LOAD: count_d = preset;
      CNT: begin
        if (en) count_d = (count > 32'd1) ? count - 32'd1 : 32'd0;
      end
      INT: begin
        flag_d = 1'b1;
        if (!auto_mode) ctrl_d[0] = 1'b0;
      end
      default: ;
    endcase
    if (preset_we) preset_d = m_data_wdata;
    if (ctrl_we) begin
      ctrl_d = m_data_wdata[3:0];
      flag_d = 1'b0;
    end
    irq_d = flag_d & ctrl_d[3];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl   <= '0;
      preset <= '0;
      count  <= '0;
      flag   <= 1'b0;
      irq    <= 1'b0;
    end else begin
      ctrl   <= ctrl_d;
      preset <= preset_d;
      count  <= count_d;
      flag   <= flag_d;
      irq    <= irq_d;
    end
  end

`ifdef DM_BRIDGE_TRACE_EN
  always @(posedge clk) begin
    if (!reset) begin
      if (ram_we)
        $display("@%h: *%h <= %h", m_inst_addr, {m_data_addr[31:2], 2'b00}, ram_merged);
      else if (ctrl_we)
        $display("@%h: *%h <= %h", m_inst_addr, {m_data_addr[31:2], 2'b00}, {28'b0, m_data_wdata[3:0]});
      else if (preset_we)
        $display("@%h: *%h <= %h", m_inst_addr, {m_data_addr[31:2], 2'b00}, m_data_wdata);
    end
  end
`else
  logic unused_trace;
  assign unused_trace = ^m_inst_addr;
`endif

endmodule
